// File: rtl/av_arb_pkg.sv
// Shared types and default widths for the Avalon-MM burst arbiter.
// Optional round-robin arbitration is enabled with AV_ARB_ROUND_ROBIN_EN.
package av_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD_RD   = 2'd1,
    RD_DATA  = 2'd2,
    WR_BURST = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant from a request vector.
// AV_ARB_ROUND_ROBIN_EN defined: search starts at ptr; undefined: channel 0 highest.
module rr_arbiter
  import av_arb_pkg::*;
#(
  parameter int N_CH  = 2,
  parameter int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
`ifdef AV_ARB_ROUND_ROBIN_EN
  input  logic [PTR_W-1:0] ptr,
`endif
  output logic [N_CH-1:0]  gnt
);

  int               start;
  logic [PTR_W-1:0] idx;

  // Walk from lowest to highest priority so the highest-priority requester is written last.
  always_comb begin
    gnt = '0;
    idx = '0;
`ifdef AV_ARB_ROUND_ROBIN_EN
    start = int'(ptr);
`else
    start = 0;
`endif
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = PTR_W'((start + k) % N_CH);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/av_burst_arbiter.sv
// Merges N_CH Avalon-MM burst masters onto one master port, one whole burst per grant.
// Define AV_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (ch0 highest).
module av_burst_arbiter
  import av_arb_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = av_arb_pkg::ADDR_W,
  parameter int DATA_W  = av_arb_pkg::DATA_W,
  parameter int BURST_W = av_arb_pkg::BURST_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH*ADDR_W-1:0]    ch_address,
  input  logic [N_CH-1:0]           ch_read,
  input  logic [N_CH-1:0]           ch_write,
  input  logic [N_CH*BURST_W-1:0]   ch_burstcount,
  input  logic [N_CH*DATA_W-1:0]    ch_writedata,
  output logic [N_CH-1:0]           ch_waitrequest,
  output logic [DATA_W-1:0]         ch_readdata,
  output logic [N_CH-1:0]           ch_readdatavalid,
  output logic [ADDR_W-1:0]         av_address,
  output logic                      av_read,
  output logic                      av_write,
  output logic [BURST_W-1:0]        av_burstcount,
  output logic [DATA_W-1:0]         av_writedata,
  output logic                      av_beginbursttransfer,
  input  logic                      av_waitrequest,
  input  logic [DATA_W-1:0]         av_readdata,
  input  logic                      av_readdatavalid,
  output logic [1:0]                dbg_state
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  arb_state_t          state_q, state_d;
  logic [N_CH-1:0]     gnt_q, gnt_d;
  logic [BURST_W-1:0]  len_q, len_d;
  logic [BURST_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic                first_q, first_d;

  logic [N_CH-1:0]     req;
  logic [N_CH-1:0]     arb_gnt;
  logic [N_CH-1:0]     sel;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BURST_W-1:0]  sel_bc;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_rd;
  logic                sel_wr;
  logic                cmd_active;
  logic                rd_beat;
  logic                wr_beat;
  logic                last_beat;

  assign req = ch_read | ch_write;

`ifdef AV_ARB_ROUND_ROBIN_EN
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_q[i]) gnt_idx = PTR_W'(i);
    end
  end

  rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt)
  );
`else
  rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_arb (
    .req (req),
    .gnt (arb_gnt)
  );
`endif

  // In IDLE the mux looks at the channel about to be granted so len and direction can be latched.
  always_comb begin
    sel       = (state_q == IDLE) ? arb_gnt : gnt_q;
    sel_addr  = '0;
    sel_bc    = '0;
    sel_wdata = '0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel[i]) begin
        sel_addr  = ch_address[i*ADDR_W +: ADDR_W];
        sel_bc    = ch_burstcount[i*BURST_W +: BURST_W];
        sel_wdata = ch_writedata[i*DATA_W +: DATA_W];
        sel_rd    = ch_read[i];
        sel_wr    = ch_write[i];
      end
    end
  end

  assign cmd_active = (state_q == CMD_RD) || (state_q == WR_BURST);
  assign rd_beat    = (state_q == RD_DATA) && av_readdatavalid;
  assign wr_beat    = (state_q == WR_BURST) && sel_wr && !av_waitrequest;
  assign last_beat  = (beat_cnt_q == len_q - BURST_W'(1));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    first_d    = 1'b0;
`ifdef AV_ARB_ROUND_ROBIN_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d      = arb_gnt;
          len_d      = (sel_bc == '0) ? BURST_W'(1) : sel_bc;
          beat_cnt_d = '0;
          first_d    = 1'b1;
          state_d    = sel_rd ? CMD_RD : WR_BURST;
        end
      end
      CMD_RD: begin
        if (!av_waitrequest) begin
          state_d    = RD_DATA;
          beat_cnt_d = '0;
        end
      end
      RD_DATA, WR_BURST: begin
        if ((state_q == RD_DATA) ? rd_beat : wr_beat) begin
          if (last_beat) begin
            state_d = IDLE;
`ifdef AV_ARB_ROUND_ROBIN_EN
            rr_ptr_d = (gnt_idx == PTR_W'(N_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
`endif
          end else begin
            beat_cnt_d = beat_cnt_q + BURST_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      first_q    <= 1'b0;
`ifdef AV_ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      first_q    <= first_d;
`ifdef AV_ARB_ROUND_ROBIN_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Burstcount comes from the latched len so a requested 0 reaches the slave as 1.
  assign av_read               = (state_q == CMD_RD);
  assign av_write              = (state_q == WR_BURST) && sel_wr;
  assign av_address            = cmd_active ? sel_addr : '0;
  assign av_burstcount         = cmd_active ? len_q : '0;
  assign av_writedata          = (state_q == WR_BURST) ? sel_wdata : '0;
  assign av_beginbursttransfer = first_q;

  assign ch_waitrequest   = ~(gnt_q & {N_CH{cmd_active && !av_waitrequest}});
  assign ch_readdatavalid = gnt_q & {N_CH{rd_beat}};
  assign ch_readdata      = (state_q == RD_DATA) ? av_readdata : '0;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_av_burst_arbiter.sv
// Scoreboard bench for av_burst_arbiter: stimulus pushes expected commands/beats, a negedge monitor checks them.
module tb_av_burst_arbiter;

  localparam int N_CH    = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int BURST_W = 5;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [N_CH*ADDR_W-1:0]  ch_address = '0;
  logic [N_CH-1:0]         ch_read = '0;
  logic [N_CH-1:0]         ch_write = '0;
  logic [N_CH*BURST_W-1:0] ch_burstcount = '0;
  logic [N_CH*DATA_W-1:0]  ch_writedata = '0;
  logic [N_CH-1:0]         ch_waitrequest;
  logic [DATA_W-1:0]       ch_readdata;
  logic [N_CH-1:0]         ch_readdatavalid;
  logic [ADDR_W-1:0]       av_address;
  logic                    av_read;
  logic                    av_write;
  logic [BURST_W-1:0]      av_burstcount;
  logic [DATA_W-1:0]       av_writedata;
  logic                    av_beginbursttransfer;
  logic                    av_waitrequest = 1'b0;
  logic [DATA_W-1:0]       av_readdata = '0;
  logic                    av_readdatavalid = 1'b0;
  logic [1:0]              dbg_state;

  av_burst_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ch_address            (ch_address),
    .ch_read               (ch_read),
    .ch_write              (ch_write),
    .ch_burstcount         (ch_burstcount),
    .ch_writedata          (ch_writedata),
    .ch_waitrequest        (ch_waitrequest),
    .ch_readdata           (ch_readdata),
    .ch_readdatavalid      (ch_readdatavalid),
    .av_address            (av_address),
    .av_read               (av_read),
    .av_write              (av_write),
    .av_burstcount         (av_burstcount),
    .av_writedata          (av_writedata),
    .av_beginbursttransfer (av_beginbursttransfer),
    .av_waitrequest        (av_waitrequest),
    .av_readdata           (av_readdata),
    .av_readdatavalid      (av_readdatavalid),
    .dbg_state             (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [38:0] exp_cmd_q[$];  // {read, write, address, burstcount}
  logic [34:0] exp_rd_q[$];   // {channel, data}
  logic [63:0] exp_wr_q[$];   // {address, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s got=none want=event t=%0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (av_beginbursttransfer) begin
        if (exp_cmd_q.size() == 0) fail_now("cmd_unexpected");
        else chk("cmd", 64'({av_read, av_write, av_address, av_burstcount}), 64'(exp_cmd_q.pop_front()));
      end
      if (|ch_readdatavalid) begin
        logic [2:0] idx;
        idx = (ch_readdatavalid == 2'b01) ? 3'd0 : (ch_readdatavalid == 2'b10) ? 3'd1 : 3'd7;
        if (exp_rd_q.size() == 0) fail_now("rd_unexpected");
        else chk("rd_beat", 64'({idx, ch_readdata}), 64'(exp_rd_q.pop_front()));
      end
      if (av_write && !av_waitrequest) begin
        if (exp_wr_q.size() == 0) fail_now("wr_unexpected");
        else chk("wr_beat", {av_address, av_writedata}, exp_wr_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(input int ch);
    int n = 0;
    forever begin
      @(negedge clk);
      if (!ch_waitrequest[ch]) break;
      n++;
      if (n > 50) begin
        fail_now("accept_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_cmd();
    int n = 0;
    forever begin
      @(negedge clk);
      if (av_read && !av_waitrequest) break;
      n++;
      if (n > 50) begin
        fail_now("cmd_timeout");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, 64'(dbg_state), 64'(0));
    chk({tag, "_av_cmd"}, 64'({av_read, av_write, av_beginbursttransfer}), 64'(0));
    chk({tag, "_av_addr"}, 64'(av_address), 64'(0));
    chk({tag, "_av_bc"}, 64'(av_burstcount), 64'(0));
    chk({tag, "_ch_wait"}, 64'(ch_waitrequest), 64'(2'b11));
    chk({tag, "_ch_rdv"}, 64'(ch_readdatavalid), 64'(0));
    chk({tag, "_ch_rdata"}, 64'(ch_readdata), 64'(0));
  endtask

  task automatic do_read(input int ch, input logic [31:0] addr, input logic [4:0] bc,
                         input logic [31:0] dbase);
    int n;
    n = (bc == 0) ? 1 : int'(bc);
    exp_cmd_q.push_back({1'b1, 1'b0, addr, 5'(n)});
    for (int j = 0; j < n; j++) exp_rd_q.push_back({3'(ch), 32'(dbase + 32'(j))});
    ch_address[ch*ADDR_W +: ADDR_W]    = addr;
    ch_burstcount[ch*BURST_W +: BURST_W] = bc;
    ch_read[ch] = 1'b1;
    wait_accept(ch);
    ch_read[ch] = 1'b0;
    for (int j = 0; j < n; j++) begin
      av_readdatavalid = 1'b1;
      av_readdata      = dbase + 32'(j);
      @(posedge clk); #1;
    end
    av_readdatavalid = 1'b0;
    av_readdata      = '0;
    @(negedge clk);
    chk("idle_after_rd", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int ch, input logic [31:0] addr, input int n,
                          input logic [31:0] dbase, input logic [7:0] stall_mask);
    exp_cmd_q.push_back({1'b0, 1'b1, addr, 5'(n)});
    for (int j = 0; j < n; j++) exp_wr_q.push_back({addr, 32'(dbase + 32'(j))});
    ch_address[ch*ADDR_W +: ADDR_W]     = addr;
    ch_burstcount[ch*BURST_W +: BURST_W] = 5'(n);
    ch_write[ch] = 1'b1;
    for (int i = 0; i < n; i++) begin
      ch_writedata[ch*DATA_W +: DATA_W] = dbase + 32'(i);
      if (stall_mask[i]) begin
        av_waitrequest = 1'b1;
        @(negedge clk);
        chk("wr_stall_wait", 64'(ch_waitrequest[ch]), 64'(1));
        @(posedge clk); #1;
        av_waitrequest = 1'b0;
      end
      wait_accept(ch);
    end
    ch_write[ch] = 1'b0;
    @(negedge clk);
    chk("idle_after_wr", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("post_rst");
    @(posedge clk); #1;

    // single 4-beat read on ch0
    do_read(0, 32'h100, 5'd4, 32'hA0);

    // 8-beat write on ch1, slave stalls beats 2 and 5
    do_write(1, 32'h200, 8, 32'hB0, 8'b0010_0100);

    // burstcount 0 is a single beat
    do_read(0, 32'h180, 5'd0, 32'h55);

    // stray readdatavalid while idle
    av_readdatavalid = 1'b1;
    av_readdata      = 32'hDEAD;
    @(negedge clk);
    chk("stray_rdv", 64'(ch_readdatavalid), 64'(0));
    chk("stray_state", 64'(dbg_state), 64'(0));
    @(posedge clk); #1;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;

    // reset after beat 2 of a 4-beat read
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h140, 5'd4});
    exp_rd_q.push_back({3'd0, 32'hE0});
    exp_rd_q.push_back({3'd0, 32'hE1});
    ch_address[0 +: ADDR_W]   = 32'h140;
    ch_burstcount[0 +: BURST_W] = 5'd4;
    ch_read[0] = 1'b1;
    wait_accept(0);
    ch_read[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      av_readdatavalid = 1'b1;
      av_readdata      = 32'hE0 + 32'(j);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    av_readdata = 32'hE2;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;
    do_read(1, 32'h500, 5'd2, 32'h70);

    // contention: both channels hold 4-beat read requests, starting from a fresh reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ch_address[0 +: ADDR_W]           = 32'h300;
    ch_address[ADDR_W +: ADDR_W]      = 32'h400;
    ch_burstcount[0 +: BURST_W]       = 5'd4;
    ch_burstcount[BURST_W +: BURST_W] = 5'd4;
    for (int b = 0; b < 4; b++) begin
      int ec;
`ifdef AV_ARB_ROUND_ROBIN_EN
      ec = b % 2;
`else
      ec = 0;
`endif
      exp_cmd_q.push_back({1'b1, 1'b0, (ec == 0) ? 32'h300 : 32'h400, 5'd4});
      for (int j = 0; j < 4; j++) exp_rd_q.push_back({3'(ec), 32'hC0 + 32'(b*4 + j)});
    end
    ch_read = 2'b11;
    for (int b = 0; b < 4; b++) begin
      wait_cmd();
      if (b == 3) ch_read = 2'b00;
      for (int j = 0; j < 4; j++) begin
        av_readdatavalid = 1'b1;
        av_readdata      = 32'hC0 + 32'(b*4 + j);
        @(posedge clk); #1;
      end
      av_readdatavalid = 1'b0;
      av_readdata      = '0;
    end
    repeat (3) @(posedge clk);
    #1;

    // ---------------- final report ----------------
    @(negedge clk);
    chk("end_state", 64'(dbg_state), 64'(0));
    chk("cmd_q_empty", 64'(exp_cmd_q.size()), 64'(0));
    chk("rd_q_empty", 64'(exp_rd_q.size()), 64'(0));
    chk("wr_q_empty", 64'(exp_wr_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/av_burst_arbiter.md
# av_burst_arbiter

Parametrised Avalon-MM burst arbiter that merges `N_CH` cache-side master channels onto one Avalon-MM master port. It generalises the per-cache, one-master-per-cache arrangement: the I-cache, the D-cache and future clients share one memory port. Each burst is granted in full to one channel. Read beats are steered back to the owner. Writes are passed through beat by beat.

## Interface
- `N_CH`, 2: number of client channels (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `BURST_W`, 5: burstcount width.
- `clk` in, 1: clock. Everything is on the rising edge.
- `reset` in, 1: asynchronous, active-high reset.
- `ch_address` in, `N_CH`x`ADDR_W`: per-channel burst start address.
- `ch_read` / `ch_write` in, `N_CH`: per-channel read or write request.
- `ch_burstcount` in, `N_CH`x`BURST_W`: beats in the burst.
- `ch_writedata` in, `N_CH`x`DATA_W`: write beat data.
- `ch_waitrequest` out, `N_CH`: per-channel stall.
- `ch_readdata` out, `DATA_W`: read beat data, shared by all channels.
- `ch_readdatavalid` out, `N_CH`: read beat valid, one-hot to the owner.
- `av_address`, `av_read`, `av_write`, `av_burstcount`, `av_writedata`, `av_beginbursttransfer` out: Avalon master command outputs.
- `av_waitrequest`, `av_readdata`, `av_readdatavalid` in: Avalon slave responses.

## Operation
- FSM states: `IDLE`, `CMD_RD`, `RD_DATA`, `WR_BURST`.
- `IDLE`:
  - The arbiter samples the `ch_read|ch_write` vector.
  - If any channel requests, it registers a one-hot grant `gnt` and the burst length `len`. A burstcount of 0 is taken as 1.
  - It moves to `CMD_RD` (read) or `WR_BURST` (write).
  - If a channel asserts both read and write, it is serviced as a read.
- `CMD_RD`:
  - `av_*` command outputs mux the granted channel's signals; `av_read`=1.
  - When `!av_waitrequest`, go to `RD_DATA` with `beat_cnt`=0.
- `RD_DATA`:
  - The command is deasserted.
  - Each `av_readdatavalid` forwards `av_readdata` and pulses `ch_readdatavalid[gnt]`.
  - `beat_cnt` increments on each beat. At `beat_cnt==len-1` with valid, go to `IDLE`.
- `WR_BURST`:
  - `av_write` = `ch_write[gnt]`; address, burstcount and writedata are muxed from the granted channel.
  - A beat is accepted on `write && !av_waitrequest`.
  - After the `len`-th accepted beat, go to `IDLE`.
  - If the channel drops `ch_write` mid-burst, the arbiter waits and holds the grant.
- `ch_waitrequest[i]` is 0 only when `i==gnt`, state is `CMD_RD` or `WR_BURST`, and `av_waitrequest`=0. Otherwise it is 1, including in `IDLE` and `RD_DATA`.
- `av_beginbursttransfer`=1 only on the first cycle of `CMD_RD` or `WR_BURST`.
- Each channel has at most one burst outstanding. No read pipelining across grants.
- `av_readdatavalid` outside `RD_DATA` is ignored and no channel sees a pulse.

## Timing
- Reset values: state `IDLE`; `gnt`=0; `beat_cnt`=0; `rr_ptr`=0; all `av_*` command outputs 0; all `ch_waitrequest`=1; `ch_readdatavalid`=0; `ch_readdata`=0.
- A request seen in `IDLE` at edge k puts the command on `av_*` in cycle k+1. Minimum turnaround is 1 idle cycle between bursts.
- `ch_readdata` and `ch_readdatavalid` are combinational from the `av_*` inputs: zero added latency.
- A write beat completes in the same cycle that `av_waitrequest` is low.
- The read burst ends on the cycle of its last valid beat. The next grant is decided in the following `IDLE` cycle.
- `reset` mid-burst aborts at once. Outstanding beats are dropped, so the slave side must also be reset.
- Arithmetic: `beat_cnt` is `BURST_W` bits. The compare uses `len-1`, and `len` ≥ 1 after the 0→1 substitution, so there is no wrap.

## Configuration
- `AV_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration.
  - `rr_ptr` moves to `gnt+1` mod `N_CH` when a burst ends.
  - The search starts at `rr_ptr`.
- `AV_ARB_ROUND_ROBIN_EN` undefined: fixed priority, with channel 0 highest. `rr_ptr` is not implemented.

## Structure
- Package `av_arb_pkg`: `arb_state_t` enum and the default width localparams (`ADDR_W`/`DATA_W`/`BURST_W`).
- Sub-module `rr_arbiter`: `N_CH` request vector and priority pointer in, one-hot grant out. Purely combinational; the macro selects rotate or fixed.
- The top module holds the FSM, counters and muxes.

## Test plan
- Single read: ch0 reads addr 0x100, burstcount 4, slave returns 4 beats 0xA0..0xA3 → `av_beginbursttransfer` pulses once; ch0 sees 4 `ch_readdatavalid` pulses with the matching data; ch1 sees none.
- Write burst with stalls: ch1 writes 8 beats to 0x200 with `av_waitrequest` high on beats 2 and 5 → exactly 8 accepted beats in order; then `IDLE`.
- Contention: ch0 and ch1 both request 4-beat reads continuously →
  - with `AV_ARB_ROUND_ROBIN_EN`: grants alternate 0,1,0,1;
  - without: ch0 gets every grant.
- Burstcount 0: ch0 reads with burstcount 0 → treated as 1; `IDLE` after 1 beat.
- Reset mid read: `reset` asserted after beat 2 of 4 → all outputs at reset values the next cycle; a fresh request afterwards gets a normal grant.
- Stray data: `av_readdatavalid`=1 in `IDLE` → no `ch_readdatavalid` pulse on any channel.
